// File: rtl/dec_lut_pkg.sv
// Shared types and width helpers for the sequential LUT decoder.
package dec_lut_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CMP,
    CALC,
    DONE
  } state_t;

  function automatic int off_bits(input int n_bits, input int idx_bits);
    return n_bits - idx_bits;
  endfunction

  function automatic longint unsigned step(input int n_bits, input int idx_bits);
    return 64'd1 << off_bits(n_bits, idx_bits);
  endfunction

endpackage

// File: rtl/dec_lut_decoder_seq_if.sv
// Request, result and LUT read-port bundle of the decoder.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// valid and its payload are held stable by the sender until that edge.
interface dec_lut_decoder_seq_if #(
  parameter int W_BITS   = 46,
  parameter int N_BITS   = 31,
  parameter int IDX_BITS = 10
);
  logic                in_valid;
  logic                in_ready;
  logic [W_BITS-1:0]   W;
  logic                lut_en;
  logic [IDX_BITS-1:0] lut_addr;
  logic [W_BITS-1:0]   lut_data;
  logic                out_valid;
  logic                out_ready;
  logic                found;
  logic [N_BITS-1:0]   N;

  modport slave (
    input  in_valid, W, lut_data, out_ready,
    output in_ready, lut_en, lut_addr, out_valid, found, N
  );

  modport master (
    output in_valid, W, lut_data, out_ready,
    input  in_ready, lut_en, lut_addr, out_valid, found, N
  );
endinterface

// File: rtl/dec_lut_rom.sv
// Synchronous-read LUT storage; contents are preloaded through the load port.
module dec_lut_rom #(
  parameter int W_BITS   = 46,
  parameter int IDX_BITS = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic [IDX_BITS-1:0] addr,
  output logic [W_BITS-1:0]   data,
  input  logic                load_en,
  input  logic [IDX_BITS-1:0] load_addr,
  input  logic [W_BITS-1:0]   load_data
);
  logic [W_BITS-1:0] mem [2**IDX_BITS];

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (en) data <= mem[addr];
  end
endmodule

// File: rtl/dec_lut_decoder_seq.sv
// Binary search of a sorted piecewise-linear LUT followed by an in-segment offset.
module dec_lut_decoder_seq
  import dec_lut_pkg::*;
#(
  parameter int W_BITS   = 46,
  parameter int N_BITS   = 31,
  parameter int IDX_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  dec_lut_decoder_seq_if.slave   bus,
  output state_t                 state
);
  localparam int OFF_BITS = off_bits(N_BITS, IDX_BITS);
  localparam int BIT_W    = $clog2(IDX_BITS + 1);

  logic [W_BITS-1:0]   w_q;
  logic [W_BITS-1:0]   base_q;
  logic [W_BITS-1:0]   off;
  logic [IDX_BITS-1:0] cur_q;
  logic [IDX_BITS-1:0] cur_upd;
  logic [IDX_BITS-1:0] next_addr;
  logic [BIT_W-1:0]    bit_q;
  logic [BIT_W-1:0]    bit_dec;
  logic                under_q;
  logic                take;
  logic                first;
  logic                in_seg;

  // bit_q == IDX_BITS marks the LUT[0] probe; later probes test bit bit_q of the index.
  always_comb begin
    take      = (bus.lut_data <= w_q);
    first     = (bit_q == BIT_W'(IDX_BITS));
    bit_dec   = bit_q - BIT_W'(1);
    cur_upd   = cur_q;
    if (take && !first) cur_upd = cur_q | (IDX_BITS'(1) << bit_q);
    next_addr = cur_upd | (IDX_BITS'(1) << bit_dec);
    off       = w_q - base_q;
    in_seg    = ((off >> OFF_BITS) == '0);
  end

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      w_q          <= '0;
      base_q       <= '0;
      cur_q        <= '0;
      bit_q        <= '0;
      under_q      <= 1'b0;
      bus.lut_en   <= 1'b0;
      bus.lut_addr <= '0;
      bus.out_valid <= 1'b0;
      bus.found    <= 1'b0;
      bus.N        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            w_q          <= bus.W;
            base_q       <= '0;
            cur_q        <= '0;
            bit_q        <= BIT_W'(IDX_BITS);
            under_q      <= 1'b0;
            bus.lut_en   <= 1'b1;
            bus.lut_addr <= '0;
            state        <= RD;
          end
        end
        RD: begin
          bus.lut_en <= 1'b0;
          state      <= CMP;
        end
        CMP: begin
          if (first && !take) begin
            under_q <= 1'b1;
            state   <= CALC;
          end else begin
            if (take) base_q <= bus.lut_data;
            cur_q <= cur_upd;
            if (!first && bit_q == '0) begin
              state <= CALC;
            end else begin
              bit_q        <= bit_dec;
              bus.lut_en   <= 1'b1;
              bus.lut_addr <= next_addr;
              state        <= RD;
            end
          end
        end
        CALC: begin
          bus.found     <= !under_q && in_seg;
          bus.N         <= (!under_q && in_seg) ? {cur_q, off[OFF_BITS-1:0]} : '0;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dec_lut_decoder_seq.sv
// Randomized and directed bench for dec_lut_decoder_seq against a linear-scan LUT model.
module tb_dec_lut_decoder_seq;
  import dec_lut_pkg::*;

  localparam int W_BITS   = 46;
  localparam int N_BITS   = 31;
  localparam int IDX_BITS = 10;
  localparam int DEPTH    = 2 ** IDX_BITS;
  localparam longint unsigned STEP = step(N_BITS, IDX_BITS);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec_lut_decoder_seq_if #(.W_BITS(W_BITS), .N_BITS(N_BITS), .IDX_BITS(IDX_BITS)) bus ();
  state_t dut_state;

  logic                load_en = 1'b0;
  logic [IDX_BITS-1:0] load_addr = '0;
  logic [W_BITS-1:0]   load_data = '0;

  dec_lut_decoder_seq #(.W_BITS(W_BITS), .N_BITS(N_BITS), .IDX_BITS(IDX_BITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (dut_state)
  );

  dec_lut_rom #(.W_BITS(W_BITS), .IDX_BITS(IDX_BITS)) rom (
    .clk       (clk),
    .en        (bus.lut_en),
    .addr      (bus.lut_addr),
    .data      (bus.lut_data),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  // scoreboard
  longint unsigned lut_m [DEPTH];
  logic [N_BITS:0] exp_q [$];
  logic [IDX_BITS-1:0] addr_log [$];
  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk) if (bus.lut_en === 1'b1) addr_log.push_back(bus.lut_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // largest i with LUT[i] <= w, then offset within that segment
  function automatic void ref_model(input longint unsigned w, output bit f,
                                    output longint unsigned n, output int idx);
    longint unsigned off;
    idx = -1;
    for (int i = 0; i < DEPTH; i++) if (lut_m[i] <= w) idx = i;
    if (idx < 0) begin
      f = 1'b0;
      n = 0;
    end else begin
      off = w - lut_m[idx];
      f   = (off < STEP);
      n   = f ? longint'(idx) * STEP + off : 0;
    end
  endfunction

  task automatic run_req(input longint unsigned w, input bit bp);
    bit f;
    longint unsigned n;
    int idx, lat, exp_lat, hold;
    logic [N_BITS:0] exp;
    logic [IDX_BITS-1:0] exp_addr [$];
    logic [N_BITS-1:0] n_seen;
    logic f_seen;
    ref_model(w, f, n, idx);
    exp_q.push_back({f, n[N_BITS-1:0]});
    exp_addr.push_back('0);
    if (idx >= 0)
      for (int b = IDX_BITS - 1; b >= 0; b--)
        exp_addr.push_back(IDX_BITS'(((idx >> (b + 1)) << (b + 1)) | (1 << b)));
    exp_lat = (idx < 0) ? 3 : 2 * (IDX_BITS + 1) + 1;

    @(negedge clk);
    check("accept_ready", bus.in_ready, 1'b1);
    addr_log.delete();
    bus.in_valid = 1'b1;
    bus.W = w[W_BITS-1:0];
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("busy_ready", bus.in_ready, 1'b0);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (bus.out_valid !== 1'b1 && lat < 100);
    check("latency", 64'(lat), 64'(exp_lat));
    exp = exp_q.pop_front();
    check("found", bus.found, exp[N_BITS]);
    check("N", bus.N, exp[N_BITS-1:0]);
    check("n_reads", 64'(addr_log.size()), 64'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < addr_log.size(); k++)
      check("lut_addr", addr_log[k], exp_addr[k]);

    f_seen = bus.found;
    n_seen = bus.N;
    hold = bp ? 5 : $urandom_range(0, 3);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (bp) begin
        bus.in_valid = 1'b1;
        bus.W = W_BITS'({$urandom, $urandom});
      end
      @(posedge clk);
      #1;
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_found", bus.found, f_seen);
      check("hold_N", bus.N, n_seen);
      if (bp) begin
        check("hold_ready", bus.in_ready, 1'b0);
        check("hold_lut_en", bus.lut_en, 1'b0);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("post_valid", bus.out_valid, 1'b0);
    check("post_ready", bus.in_ready, 1'b1);
  endtask

  task automatic reset_in_cmp4(input longint unsigned w);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.W = w[W_BITS-1:0];
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("pre_rst_state", dut_state, CMP);
    #1 rst = 1'b1;
    #1;
    check("arst_ready", bus.in_ready, 1'b1);
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_found", bus.found, 1'b0);
    check("arst_N", bus.N, '0);
    check("arst_lut_en", bus.lut_en, 1'b0);
    check("arst_lut_addr", bus.lut_addr, '0);
    check("arst_state", dut_state, IDLE);
    addr_log.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_no_reads", 64'(addr_log.size()), 0);
    check("arst_idle_valid", bus.out_valid, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint unsigned w;
    bus.in_valid = 1'b0;
    bus.W = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      lut_m[i] = 1000 + longint'(i) * STEP;
      @(negedge clk);
      load_en = 1'b1;
      load_addr = IDX_BITS'(i);
      load_data = W_BITS'(lut_m[i]);
    end
    @(negedge clk);
    load_en = 1'b0;
    check("rst_ready", bus.in_ready, 1'b1);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_found", bus.found, 1'b0);
    check("rst_N", bus.N, '0);
    check("rst_lut_en", bus.lut_en, 1'b0);
    check("rst_lut_addr", bus.lut_addr, '0);
    check("rst_state", dut_state, IDLE);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_req(1000 + 64'd1073741823, 1'b0);
    run_req(999, 1'b0);
    run_req(1000, 1'b0);
    run_req(1000 + (64'd1 << 31) - 1, 1'b0);
    run_req(1000 + (64'd1 << 31), 1'b0);
    run_req(1000 + 64'd12345678, 1'b1);
    reset_in_cmp4(1000 + 64'd777777777);
    run_req(1000 + 5 * STEP + 7, 1'b0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: w = $urandom_range(0, 999);
        1: w = lut_m[$urandom_range(0, DEPTH - 1)] + $urandom_range(0, 32'(STEP - 1));
        2: w = lut_m[$urandom_range(0, DEPTH - 1)] + STEP - $urandom_range(0, 2);
        3: w = 1000 + (64'd1 << 31) + $urandom_range(0, 1000000);
        default: w = {$urandom, $urandom} & ((64'd1 << W_BITS) - 1);
      endcase
      run_req(w, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
